// File: rtl/addsub_pkg.sv
// Shared encodings and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Signed limit of a w-bit word: most negative when neg=1, most positive otherwise.
    function automatic logic [63:0] sat_limit(input logic neg, input int unsigned w);
        logic [63:0] msb;
        msb = 64'd1 << (w - 1);
        return neg ? msb : msb - 64'd1;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [DIGIT:0] c;

    always_comb begin
        s_o  = '0;
        c    = '0;
        c[0] = c_i;
        for (int j = 0; j < DIGIT; j++) begin
            s_o[j]   = a_i[j] ^ b_i[j] ^ c[j];
            c[j+1]   = (a_i[j] & b_i[j]) | (c[j] & (a_i[j] ^ b_i[j]));
        end
    end

    assign c_o     = c[DIGIT];
    assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/sub, LSB digit first, valid/ready on both sides.
// Define ADDSUB_SATURATE_EN to clamp the result to the signed limit on overflow.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_c, dig_cm;

    assign dig_a = a_q[int'(k_q)*DIGIT +: DIGIT];
    assign dig_b = b_q[int'(k_q)*DIGIT +: DIGIT];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i     (dig_a),
        .b_i     (dig_b),
        .c_i     (carry_q),
        .s_o     (dig_s),
        .c_o     (dig_c),
        .c_msb_o (dig_cm)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        k_d       = k_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtract is folded into the operands: a + ~b + ~c_in.
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    carry_d = c_in ^ op;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*DIGIT +: DIGIT] = dig_s;
                carry_d = dig_c;
                k_d     = k_q + 1'b1;
                if (k_q == KLAST) begin
                    c_out_d = dig_c;
                    ovf_d   = dig_c ^ dig_cm;
                    k_d     = '0;
                    state_d = DONE;
`ifdef ADDSUB_SATURATE_EN
                    if (dig_c ^ dig_cm)
                        sum_d = WIDTH'(sat_limit(a_q[WIDTH-1], WIDTH));
`endif
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
